// File: rtl/tf_row_stream_buf.sv
// tf_row_stream_buf: row FIFO between the twiddle-factor generator and the PE array.
// Each stored bundle is streamed out as LANES/OUT_LANES narrower beats.
module tf_row_stream_buf #(
    parameter int DW        = 256,
    parameter int LANES     = 16,
    parameter int OUT_LANES = 4,
    parameter int DEPTH     = 4,
    localparam int NB = LANES / OUT_LANES,
    localparam int BW = NB > 1 ? $clog2(NB) : 1,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic [LANES*DW-1:0]     in_tf,
    input  logic                    in_last,
    output logic                    in_rdy,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [OUT_LANES*DW-1:0] out_tf,
    output logic [BW-1:0]           out_beat,
    output logic                    out_last,
    output logic [LW-1:0]           level,
    output logic                    ovf
);
    typedef enum logic {EMPTY, STREAM} state_t;

    state_t              state, state_n;
    logic [LANES*DW:0]   mem [DEPTH];
    logic [LANES*DW:0]   head;
    logic [AW-1:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [BW-1:0]       beat, beat_n;
    logic [LW-1:0]       level_n;
    logic                ovf_n, push, pop, beat_end;

    assign in_rdy   = level != LW'(DEPTH);
    assign push     = in_vld & in_rdy;
    assign out_vld  = state == STREAM;
    assign beat_end = beat == BW'(NB - 1);
    assign pop      = out_vld & out_rdy & beat_end;
    assign head     = mem[rd_ptr];
    // Gated by out_vld so the beat bus reads zero while empty or in reset.
    assign out_tf   = out_vld ? head[int'(beat)*OUT_LANES*DW +: OUT_LANES*DW] : '0;
    assign out_beat = beat;
    assign out_last = out_vld & head[LANES*DW] & beat_end;

    always_comb begin
        wr_ptr_n = wr_ptr + AW'(push);
        rd_ptr_n = rd_ptr + AW'(pop);
        level_n  = level + LW'(push) - LW'(pop);
        ovf_n    = ovf | (in_vld & ~in_rdy);
        beat_n   = (out_vld & out_rdy) ? (beat_end ? '0 : beat + 1'b1) : beat;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            level_n  = '0;
            ovf_n    = 1'b0;
            beat_n   = '0;
        end
        state_n = level_n != '0 ? STREAM : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            beat   <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            level  <= level_n;
            ovf    <= ovf_n;
            beat   <= beat_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= {in_last, in_tf};
    end
endmodule

// File: tb/tb_tf_row_stream_buf.sv
// tb_tf_row_stream_buf: directed checks of the twiddle row FIFO and beat streaming.
module tb_tf_row_stream_buf;
    localparam int DW = 256, LANES = 16, OL = 4, DEPTH = 4;

    logic                 clk = 0, rst_n = 1, flush = 0, in_vld = 0, in_last = 0, out_rdy = 0;
    logic [LANES*DW-1:0]  in_tf = '0;
    logic                 in_rdy, out_vld, out_last, ovf;
    logic [OL*DW-1:0]     out_tf;
    logic [1:0]           out_beat;
    logic [2:0]           level;
    int                   checks = 0, failures = 0;
    int                   q[$];
    int                   nb, eb;

    tf_row_stream_buf #(.DW(DW), .LANES(LANES), .OUT_LANES(OL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_tf(in_tf),
        .in_last(in_last), .in_rdy(in_rdy), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_tf(out_tf), .out_beat(out_beat), .out_last(out_last), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] lane_val(int v);
        return {32'(v), 192'd0, 32'(v)};
    endfunction

    function automatic logic [LANES*DW-1:0] bundle(int base);
        logic [LANES*DW-1:0] b;
        for (int k = 0; k < LANES; k++) b[k*DW +: DW] = lane_val(base + k);
        return b;
    endfunction

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(string tag, int base, int b, bit last);
        check({tag, "_vld"}, 256'(out_vld), 256'(1));
        check({tag, "_beat"}, 256'(out_beat), 256'(b));
        for (int j = 0; j < OL; j++)
            check({tag, "_lane"}, out_tf[j*DW +: DW], lane_val(base + b*OL + j));
        check({tag, "_last"}, 256'(out_last), 256'(last && b == 3));
    endtask

    task automatic push_one(int base, bit last);
        in_vld = 1; in_tf = bundle(base); in_last = last;
        tick;
        in_vld = 0; in_last = 0;
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        check("rst_vld", 256'(out_vld), 256'(0));
        check("rst_rdy", 256'(in_rdy), 256'(1));
        check("rst_level", 256'(level), 256'(0));
        check("rst_ovf", 256'(ovf), 256'(0));
        check("rst_beat", 256'(out_beat), 256'(0));
        check("rst_last", 256'(out_last), 256'(0));
        check("rst_tf", out_tf[DW-1:0], 256'(0));
        tick; tick;
        rst_n = 1;
        tick;

        // single bundle, four beats, lane k = k+1
        out_rdy = 1;
        push_one(1, 1);
        for (int b = 0; b < 4; b++) begin
            check_beat("t1", 1, b, 1);
            tick;
        end
        check("t1_level", 256'(level), 256'(0));
        check("t1_vld_end", 256'(out_vld), 256'(0));

        // fill, overflow, drain in order
        out_rdy = 0;
        push_one(100, 0); push_one(200, 1); push_one(300, 0); push_one(400, 1);
        check("t2_level", 256'(level), 256'(4));
        check("t2_rdy", 256'(in_rdy), 256'(0));
        push_one(500, 1);
        check("t2_ovf", 256'(ovf), 256'(1));
        check("t2_level_drop", 256'(level), 256'(4));
        out_rdy = 1;
        for (int e = 0; e < 4; e++)
            for (int b = 0; b < 4; b++) begin
                check_beat("t2", (e + 1) * 100, b, e[0]);
                tick;
            end
        check("t2_empty", 256'(out_vld), 256'(0));
        check("t2_ovf_sticky", 256'(ovf), 256'(1));

        // backpressure toggling from beat 1
        out_rdy = 0;
        push_one(600, 1);
        out_rdy = 1;
        tick;
        eb = 1;
        for (int i = 0; eb < 4 && i < 20; i++) begin
            out_rdy = i[0];
            check_beat("t3", 600, eb, 1);
            tick;
            if (i[0]) eb++;
        end
        check("t3_done", 256'(eb), 256'(4));
        check("t3_empty", 256'(out_vld), 256'(0));

        // simultaneous push and pop at level 2 over pointer wrap
        out_rdy = 0;
        push_one(1000, 0); push_one(1100, 0);
        q = {1000, 1100};
        nb = 1200;
        out_rdy = 1;
        for (int p = 0; p < 8; p++)
            for (int b = 0; b < 4; b++) begin
                check_beat("t4", q[0], b, 0);
                if (b == 3) begin in_vld = 1; in_tf = bundle(nb); end
                tick;
                in_vld = 0;
                if (b == 3) begin
                    void'(q.pop_front());
                    q.push_back(nb);
                    nb += 100;
                    check("t4_level", 256'(level), 256'(2));
                end
            end

        // flush with ovf set, level 3, beat 2, concurrent offer
        out_rdy = 0;
        push_one(nb, 0);
        out_rdy = 1;
        tick; tick;
        out_rdy = 0;
        check("t5_pre_ovf", 256'(ovf), 256'(1));
        check("t5_pre_level", 256'(level), 256'(3));
        check("t5_pre_beat", 256'(out_beat), 256'(2));
        flush = 1; in_vld = 1; in_tf = bundle(9000);
        tick;
        flush = 0; in_vld = 0;
        check("t5_level", 256'(level), 256'(0));
        check("t5_ovf", 256'(ovf), 256'(0));
        check("t5_vld", 256'(out_vld), 256'(0));
        check("t5_rdy", 256'(in_rdy), 256'(1));
        check("t5_beat", 256'(out_beat), 256'(0));
        push_one(950, 1);
        check_beat("t5_after", 950, 0, 1);

        // async reset mid-transfer
        flush = 1;
        tick;
        flush = 0;
        push_one(700, 0); push_one(800, 0);
        out_rdy = 1;
        tick;
        out_rdy = 0;
        check("t6_pre_beat", 256'(out_beat), 256'(1));
        check("t6_pre_level", 256'(level), 256'(2));
        #2 rst_n = 0;
        #1;
        check("t6_vld", 256'(out_vld), 256'(0));
        check("t6_beat", 256'(out_beat), 256'(0));
        check("t6_level", 256'(level), 256'(0));
        check("t6_rdy", 256'(in_rdy), 256'(1));
        check("t6_last", 256'(out_last), 256'(0));
        tick;
        rst_n = 1;
        out_rdy = 1;
        tick;
        check("t6_no_resume", 256'(out_vld), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
